// File: rtl/calc_pkg.sv
// Shared constants for the sequential calculator controller.
// Opcodes, one-hot state indices, default operand width.
package calc_pkg;

  localparam int unsigned CALC_WIDTH = 16;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam int unsigned S_I      = 0;
  localparam int unsigned S_GET_A  = 1;
  localparam int unsigned S_GET_B  = 2;
  localparam int unsigned S_GET_OP = 3;
  localparam int unsigned S_ADD    = 4;
  localparam int unsigned S_SUB    = 5;
  localparam int unsigned S_MUL    = 6;
  localparam int unsigned S_DIV    = 7;
  localparam int unsigned S_ERR    = 8;
  localparam int unsigned S_DONE   = 9;
  localparam int unsigned NUM_ST   = 10;

  typedef enum logic [NUM_ST-1:0] {
    ST_I      = 10'b00_0000_0001,
    ST_GET_A  = 10'b00_0000_0010,
    ST_GET_B  = 10'b00_0000_0100,
    ST_GET_OP = 10'b00_0000_1000,
    ST_ADD    = 10'b00_0001_0000,
    ST_SUB    = 10'b00_0010_0000,
    ST_MUL    = 10'b00_0100_0000,
    ST_DIV    = 10'b00_1000_0000,
    ST_ERR    = 10'b01_0000_0000,
    ST_DONE   = 10'b10_0000_0000
  } state_e;

  typedef enum logic {
    IT_MUL = 1'b0,
    IT_DIV = 1'b1
  } it_mode_e;

endpackage

// File: rtl/calc_iter_unit.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle.
// Divider path only exists when CALC_DIV_EN is defined.
module calc_iter_unit
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  it_mode_e         mode_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic             busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] opd_q, opd_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] step_lo, step_hi;
  logic             ld_div;

  assign mul_sum = {1'b0, hi_q}
                 + (lo_q[0] ? {1'b0, opd_q} : '0);

`ifdef CALC_DIV_EN
  logic           div_q;
  logic [WIDTH:0] div_sh, div_trial;

  assign ld_div    = (mode_i == IT_DIV);
  assign div_sh    = {hi_q, lo_q[WIDTH-1]};
  assign div_trial = div_sh - {1'b0, opd_q};

  always_ff @(posedge clk_i) begin
    if (rst_i)        div_q <= 1'b0;
    else if (start_i) div_q <= ld_div;
  end

  always_comb begin
    step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    step_hi = mul_sum[WIDTH:1];
    if (div_q) begin
      // Restore by keeping the shifted value when the trial goes negative
      if (!div_trial[WIDTH]) begin
        step_hi = div_trial[WIDTH-1:0];
        step_lo = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = div_sh[WIDTH-1:0];
        step_lo = {lo_q[WIDTH-2:0], 1'b0};
      end
    end
  end
`else
  logic unused_mode;

  assign ld_div      = 1'b0;
  assign unused_mode = (mode_i == IT_DIV);
  assign step_lo     = {mul_sum[0], lo_q[WIDTH-1:1]};
  assign step_hi     = mul_sum[WIDTH:1];
`endif

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    opd_d  = opd_q;
    lo_d   = lo_q;
    hi_d   = hi_q;
    if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      opd_d  = ld_div ? b_i : a_i;
      lo_d   = ld_div ? a_i : b_i;
      hi_d   = '0;
    end else if (busy_q) begin
      lo_d  = step_lo;
      hi_d  = step_hi;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      opd_q  <= '0;
      lo_q   <= '0;
      hi_q   <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      opd_q  <= opd_d;
      lo_q   <= lo_d;
      hi_q   <= hi_d;
    end
  end

  // Result is the outcome of the iteration performed in the done cycle
  assign busy_o = busy_q;
  assign done_o = busy_q && (cnt_q == LAST);
  assign lo_o   = step_lo;
  assign hi_o   = step_hi;

endmodule

// File: rtl/calc_seq_ctrl.sv
// Calculator sequencer: operand/opcode entry FSM driving an iterative unit.
// Define CALC_DIV_EN to build the divider; otherwise opcode 11 errors.
module calc_seq_ctrl
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] In,
  input  logic             ButL,
  input  logic             ButR,
  input  logic             ButD,
  output logic [WIDTH-1:0] C,
  output logic             Flag,
  output logic             Done,
  output logic             QI,
  output logic             QGet_A,
  output logic             QGet_B,
  output logic             QGet_Op,
  output logic             QAdd,
  output logic             QSub,
  output logic             QMul,
  output logic             QDiv,
  output logic             QErr,
  output logic             QDone
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] prim_q, prim_d;
  logic [WIDTH-1:0] sec_q, sec_d;
  logic             flag_q, flag_d;
  logic             sel_q, sel_d;

  logic             it_start, it_busy, it_done;
  it_mode_e         it_mode;
  logic [WIDTH-1:0] it_lo, it_hi;
  logic [WIDTH:0]   add_w;

  assign add_w = {1'b0, a_q} + {1'b0, b_q};

  calc_iter_unit #(.WIDTH(WIDTH)) u_iter (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .start_i (it_start),
    .mode_i  (it_mode),
    .a_i     (a_q),
    .b_i     (b_q),
    .busy_o  (it_busy),
    .done_o  (it_done),
    .lo_o    (it_lo),
    .hi_o    (it_hi)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    prim_d   = prim_q;
    sec_d    = sec_q;
    flag_d   = flag_q;
    sel_d    = sel_q;
    it_start = 1'b0;
    it_mode  = IT_MUL;
    unique case (state_q)
      ST_I: if (ButR) state_d = ST_GET_A;
      ST_GET_A: begin
        if (ButL) state_d = ST_I;
        else if (ButR) begin
          a_d     = In;
          state_d = ST_GET_B;
        end
      end
      ST_GET_B: begin
        if (ButL) state_d = ST_I;
        else if (ButR) begin
          b_d     = In;
          state_d = ST_GET_OP;
        end
      end
      ST_GET_OP: begin
        if (ButL) state_d = ST_I;
        else if (ButR) begin
          op_d = In[1:0];
          unique case (In[1:0])
            OP_ADD: state_d = ST_ADD;
            OP_SUB: state_d = ST_SUB;
            OP_MUL: begin
              state_d  = ST_MUL;
              it_start = 1'b1;
            end
            default: begin
`ifdef CALC_DIV_EN
              state_d  = ST_DIV;
              it_start = (b_q != '0);
              it_mode  = IT_DIV;
`else
              state_d  = ST_ERR;
`endif
            end
          endcase
        end
      end
      ST_ADD: begin
        prim_d  = add_w[WIDTH-1:0];
        flag_d  = add_w[WIDTH];
        sec_d   = '0;
        sel_d   = 1'b0;
        state_d = ST_DONE;
      end
      ST_SUB: begin
        prim_d  = a_q - b_q;
        flag_d  = (a_q < b_q);
        sec_d   = '0;
        sel_d   = 1'b0;
        state_d = ST_DONE;
      end
      ST_MUL, ST_DIV: begin
        if (state_q == ST_DIV && b_q == '0) begin
          state_d = ST_ERR;
        end else if (it_busy && it_done) begin
          prim_d  = it_lo;
          sec_d   = it_hi;
          flag_d  = (it_hi != '0);
          sel_d   = 1'b0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (ButD) sel_d = ~sel_q;
        if (ButR) state_d = ST_I;
      end
      ST_ERR: if (ButR || ButL) state_d = ST_I;
      default: state_d = ST_I;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_I;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      prim_q  <= '0;
      sec_q   <= '0;
      flag_q  <= 1'b0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      prim_q  <= prim_d;
      sec_q   <= sec_d;
      flag_q  <= flag_d;
      sel_q   <= sel_d;
    end
  end

  assign QI      = state_q[S_I];
  assign QGet_A  = state_q[S_GET_A];
  assign QGet_B  = state_q[S_GET_B];
  assign QGet_Op = state_q[S_GET_OP];
  assign QAdd    = state_q[S_ADD];
  assign QSub    = state_q[S_SUB];
  assign QMul    = state_q[S_MUL];
`ifdef CALC_DIV_EN
  assign QDiv    = state_q[S_DIV];
`else
  assign QDiv    = 1'b0;
`endif
  assign QErr    = state_q[S_ERR];
  assign QDone   = state_q[S_DONE];

  assign Done = QDone;
  assign C    = QDone ? (sel_q ? sec_q : prim_q) : '0;
  assign Flag = QDone ? flag_q : QErr;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Self-checking bench for calc_seq_ctrl against an arithmetic reference model.
// Expectations follow CALC_DIV_EN when it is defined for the build.
module tb_calc_seq_ctrl;

  localparam logic [9:0] T_I    = 10'd1;
  localparam logic [9:0] T_GA   = 10'd2;
  localparam logic [9:0] T_GB   = 10'd4;
  localparam logic [9:0] T_GO   = 10'd8;
  localparam logic [9:0] T_ADD  = 10'd16;
  localparam logic [9:0] T_SUB  = 10'd32;
  localparam logic [9:0] T_MUL  = 10'd64;
  localparam logic [9:0] T_DIV  = 10'd128;
  localparam logic [9:0] T_ERR  = 10'd256;
  localparam logic [9:0] T_DONE = 10'd512;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] In = '0;
  logic        ButL = 1'b0, ButR = 1'b0, ButD = 1'b0;
  logic [15:0] C;
  logic        Flag, Done;
  logic        QI, QGet_A, QGet_B, QGet_Op, QAdd, QSub;
  logic        QMul, QDiv, QErr, QDone;

  int checks = 0;
  int errors = 0;

  calc_seq_ctrl #(.WIDTH(16)) dut (
    .Clk(Clk), .Reset(Reset), .In(In),
    .ButL(ButL), .ButR(ButR), .ButD(ButD),
    .C(C), .Flag(Flag), .Done(Done),
    .QI(QI), .QGet_A(QGet_A), .QGet_B(QGet_B),
    .QGet_Op(QGet_Op), .QAdd(QAdd), .QSub(QSub),
    .QMul(QMul), .QDiv(QDiv), .QErr(QErr), .QDone(QDone)
  );

  always #5 Clk = ~Clk;

  function automatic logic [9:0] st();
    return {QDone, QErr, QDiv, QMul, QSub,
            QAdd, QGet_Op, QGet_B, QGet_A, QI};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic press(input logic l, input logic r, input logic d);
    ButL = l; ButR = r; ButD = d;
    tick();
    ButL = 1'b0; ButR = 1'b0; ButD = 1'b0;
  endtask

  task automatic enter(input logic [15:0] a, input logic [15:0] b,
                       input logic [1:0] op);
    logic [15:0] rnd;
    rnd = 16'($urandom);
    chk("idle", 32'(st()), 32'(T_I));
    press(0, 1, 0);
    chk("get_a", 32'(st()), 32'(T_GA));
    In = a;
    press(0, 1, 0);
    chk("get_b", 32'(st()), 32'(T_GB));
    In = b;
    press(0, 1, 0);
    chk("get_op", 32'(st()), 32'(T_GO));
    In = {rnd[15:2], op};
    press(0, 1, 0);
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic [1:0] op, input bit noisy);
    logic [31:0] wa, wb, wide;
    logic [15:0] ep, es;
    logic        ef;
    bit          err;
    int          ecyc, n;
    logic [9:0]  ost;
    logic [2:0]  r3;
    logic        ex;
    wa = {16'b0, a};
    wb = {16'b0, b};
    ep = '0; es = '0; ef = 1'b0; err = 0; ecyc = 1; ost = T_ADD;
    case (op)
      2'b00: begin
        wide = wa + wb;
        ep = wide[15:0]; ef = wide[16];
      end
      2'b01: begin
        ep = a - b; ef = (a < b); ost = T_SUB;
      end
      2'b10: begin
        wide = wa * wb;
        ep = wide[15:0]; es = wide[31:16];
        ef = (es != 0); ecyc = 16; ost = T_MUL;
      end
      default: begin
`ifdef CALC_DIV_EN
        if (b == 0) err = 1;
        else begin
          ep = a / b; es = a % b;
          ef = (es != 0); ecyc = 16; ost = T_DIV;
        end
`else
        err = 1;
`endif
      end
    endcase
    enter(a, b, op);
    if (err) begin
`ifdef CALC_DIV_EN
      chk("div_b0_state", 32'(st()), 32'(T_DIV));
      chk("div_b0_c", 32'(C), 32'h0);
      tick();
`endif
      chk("err_state", 32'(st()), 32'(T_ERR));
      chk("err_c", 32'(C), 32'h0);
      chk("err_flag", 32'(Flag), 32'h1);
      chk("err_done", 32'(Done), 32'h0);
      ex = 1'($urandom_range(0, 1));
      press(ex, !ex, 0);
      chk("err_exit", 32'(st()), 32'(T_I));
      return;
    end
    n = 0;
    while (st() == ost && n < 40) begin
      chk("busy_c", 32'(C), 32'h0);
      chk("busy_flag", 32'(Flag), 32'h0);
      n++;
      if (noisy) begin
        r3 = 3'($urandom);
        ButL = r3[0]; ButR = r3[1]; ButD = r3[2];
      end
      tick();
    end
    ButL = 1'b0; ButR = 1'b0; ButD = 1'b0;
    chk("op_cycles", 32'(n), 32'(ecyc));
    chk("done_state", 32'(st()), 32'(T_DONE));
    chk("done_out", 32'(Done), 32'h1);
    chk("primary", 32'(C), 32'(ep));
    chk("flag", 32'(Flag), 32'(ef));
    press(0, 0, 1);
    chk("secondary", 32'(C), 32'(es));
    press(0, 0, 1);
    chk("primary_again", 32'(C), 32'(ep));
    press(0, 1, 0);
    chk("ack_state", 32'(st()), 32'(T_I));
    chk("ack_c", 32'(C), 32'h0);
    chk("ack_flag", 32'(Flag), 32'h0);
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic [1:0]  rop;
    tick();
    tick();
    chk("rst_state", 32'(st()), 32'(T_I));
    chk("rst_c", 32'(C), 32'h0);
    chk("rst_flag", 32'(Flag), 32'h0);
    chk("rst_done", 32'(Done), 32'h0);
    Reset = 1'b0;
    tick();
    chk("post_rst", 32'(st()), 32'(T_I));

    run_op(16'hFFFF, 16'h0002, 2'b00, 1);
    run_op(16'h0003, 16'h0005, 2'b01, 1);
    run_op(16'h0100, 16'h0300, 2'b10, 1);
    run_op(16'd100, 16'd7, 2'b11, 1);
    run_op(16'd100, 16'd0, 2'b11, 0);
    run_op(16'h1234, 16'h1234, 2'b01, 0);
    run_op(16'hFFFF, 16'hFFFF, 2'b10, 0);
    run_op(16'hFFFF, 16'h0001, 2'b11, 0);
    run_op(16'h0005, 16'h0009, 2'b11, 0);

    // Cancel paths, including ButL beating ButR in QGet_B
    press(0, 1, 0);
    press(1, 1, 0);
    chk("cancel_a", 32'(st()), 32'(T_I));
    press(0, 1, 0);
    In = 16'h0011;
    press(0, 1, 0);
    press(1, 1, 0);
    chk("cancel_b_prio", 32'(st()), 32'(T_I));
    press(0, 1, 0);
    press(0, 1, 0);
    press(0, 1, 0);
    chk("at_get_op", 32'(st()), 32'(T_GO));
    press(1, 0, 0);
    chk("cancel_op", 32'(st()), 32'(T_I));

    // Reset in the fifth QMul cycle
    enter(16'h0100, 16'h0300, 2'b10);
    chk("mul_entered", 32'(st()), 32'(T_MUL));
    for (int i = 0; i < 4; i++) tick();
    chk("mul_cycle5", 32'(st()), 32'(T_MUL));
    Reset = 1'b1;
    tick();
    chk("midrst_state", 32'(st()), 32'(T_I));
    chk("midrst_c", 32'(C), 32'h0);
    chk("midrst_flag", 32'(Flag), 32'h0);
    chk("midrst_done", 32'(Done), 32'h0);
    Reset = 1'b0;
    tick();
    run_op(16'h0007, 16'h0006, 2'b10, 0);

    for (int k = 0; k < 24; k++) begin
      ra  = 16'($urandom);
      rb  = ($urandom_range(0, 5) == 0) ? 16'($urandom_range(0, 3))
                                        : 16'($urandom);
      rop = 2'($urandom_range(0, 3));
      run_op(ra, rb, rop, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
